// File: rtl/cpu_pkg.sv
// Shared CPU decode definitions: instruction field positions, decoded-field
// payload and the decode-register state encoding.
package cpu_pkg;

  localparam int unsigned INSTR_BITS = 32;

  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned RS_MSB     = 25;
  localparam int unsigned RS_LSB     = 21;
  localparam int unsigned RT_MSB     = 20;
  localparam int unsigned RT_LSB     = 16;
  localparam int unsigned RD_MSB     = 15;
  localparam int unsigned RD_LSB     = 11;
  localparam int unsigned SHAMT_MSB  = 10;
  localparam int unsigned SHAMT_LSB  = 6;
  localparam int unsigned IMM_MSB    = 20;
  localparam int unsigned IMM_LSB    = 0;
  localparam int unsigned INSMSB_BIT = 31;

  localparam int unsigned OPCODE_W = OPCODE_MSB - OPCODE_LSB + 1;
  localparam int unsigned REG_W    = RS_MSB - RS_LSB + 1;
  localparam int unsigned SHAMT_W  = SHAMT_MSB - SHAMT_LSB + 1;
  localparam int unsigned IMM_W    = IMM_MSB - IMM_LSB + 1;
  localparam int unsigned STAT_W   = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } dec_state_e;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [REG_W-1:0]    rs;
    logic [REG_W-1:0]    rt;
    logic [REG_W-1:0]    rd;
    logic [SHAMT_W-1:0]  shamt;
    logic [IMM_W-1:0]    imm;
    logic                insmsb;
  } instr_fields_t;

endpackage

// File: rtl/instr_fields.sv
// Purely combinational slicing of a raw instruction word into its fields.
module instr_fields
  import cpu_pkg::*;
(
  input  logic [INSTR_BITS-1:0] instr,
  output instr_fields_t         fields
);

  always_comb begin
    fields        = '0;
    fields.opcode = instr[OPCODE_MSB:OPCODE_LSB];
    fields.rs     = instr[RS_MSB:RS_LSB];
    fields.rt     = instr[RT_MSB:RT_LSB];
    fields.rd     = instr[RD_MSB:RD_LSB];
    fields.shamt  = instr[SHAMT_MSB:SHAMT_LSB];
    fields.imm    = instr[IMM_MSB:IMM_LSB];
    fields.insmsb = instr[INSMSB_BIT];
  end

endmodule

// File: rtl/instr_decode_reg.sv
// Two-entry skid buffer between fetch and operand stage; the head entry is
// held in decoded form on the registered out_* fields.
// Optional INSTR_DECODE_STATS_EN adds saturating decode/stall counters.
module instr_decode_reg
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W    = 32,
  parameter int unsigned INSTR_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PC_W-1:0]     in_pc,
  input  logic [INSTR_W-1:0]  in_instr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_W-1:0]     out_pc,
  output logic [OPCODE_W-1:0] out_opcode,
  output logic [REG_W-1:0]    out_rs,
  output logic [REG_W-1:0]    out_rt,
  output logic [REG_W-1:0]    out_rd,
  output logic [IMM_W-1:0]    out_imm,
  output logic                out_insmsb,
`ifdef INSTR_DECODE_STATS_EN
  output logic [STAT_W-1:0]   stat_decoded,
  output logic [STAT_W-1:0]   stat_stall,
`endif
  output logic [SHAMT_W-1:0]  out_shamt
);

  dec_state_e          state_q, state_d;
  logic [PC_W-1:0]     tail_pc_q;
  logic [INSTR_W-1:0]  tail_instr_q;
  logic                accept_c, consume_c;
  logic                head_from_in, head_from_tail, tail_load;
  logic                in_ready_d, out_valid_d;
  logic [PC_W-1:0]     head_pc_d;
  logic [INSTR_W-1:0]  head_instr_d;
  instr_fields_t       head_fields;

  assign accept_c  = in_valid & in_ready;
  assign consume_c = out_valid & out_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  // Next state and entry-load controls; flush overrides everything.
  always_comb begin
    state_d        = state_q;
    head_from_in   = 1'b0;
    head_from_tail = 1'b0;
    tail_load      = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept_c) begin
            state_d      = ST_ONE;
            head_from_in = 1'b1;
          end
        end
        ST_ONE: begin
          unique case ({accept_c, consume_c})
            2'b10: begin
              state_d   = ST_FULL;
              tail_load = 1'b1;
            end
            2'b01: state_d = ST_EMPTY;
            2'b11: head_from_in = 1'b1;
            default: state_d = ST_ONE;
          endcase
        end
        ST_FULL: begin
          if (consume_c) begin
            state_d        = ST_ONE;
            head_from_tail = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Output decode for the handshake flags, registered below.
  always_comb begin
    in_ready_d  = 1'b1;
    out_valid_d = 1'b0;
    if (state_d == ST_FULL)  in_ready_d  = 1'b0;
    if (state_d != ST_EMPTY) out_valid_d = 1'b1;
  end

  assign head_pc_d    = head_from_tail ? tail_pc_q    : in_pc;
  assign head_instr_d = head_from_tail ? tail_instr_q : in_instr;

  instr_fields u_fields (
    .instr  (head_instr_d),
    .fields (head_fields)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
    end
  end

  // Tail entry only ever loads from fetch while the head is blocked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tail_pc_q    <= '0;
      tail_instr_q <= '0;
    end else if (tail_load) begin
      tail_pc_q    <= in_pc;
      tail_instr_q <= in_instr;
    end
  end

  // Head entry; fields hold their last value while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_pc     <= '0;
      out_opcode <= '0;
      out_rs     <= '0;
      out_rt     <= '0;
      out_rd     <= '0;
      out_imm    <= '0;
      out_insmsb <= 1'b0;
      out_shamt  <= '0;
    end else if (head_from_in || head_from_tail) begin
      out_pc     <= head_pc_d;
      out_opcode <= head_fields.opcode;
      out_rs     <= head_fields.rs;
      out_rt     <= head_fields.rt;
      out_rd     <= head_fields.rd;
      out_imm    <= head_fields.imm;
      out_insmsb <= head_fields.insmsb;
      out_shamt  <= head_fields.shamt;
    end
  end

`ifdef INSTR_DECODE_STATS_EN
  // Saturating activity counters, cleared by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_decoded <= '0;
      stat_stall   <= '0;
    end else if (flush) begin
      stat_decoded <= '0;
      stat_stall   <= '0;
    end else begin
      if (consume_c && stat_decoded != {STAT_W{1'b1}})
        stat_decoded <= stat_decoded + STAT_W'(1);
      if (out_valid && !out_ready && stat_stall != {STAT_W{1'b1}})
        stat_stall <= stat_stall + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_instr_decode_reg.sv
// Directed bench for instr_decode_reg; inputs change and outputs are
// sampled on the falling edge.
module tb_instr_decode_reg;
  import cpu_pkg::*;

  localparam int unsigned PC_W    = 32;
  localparam int unsigned INSTR_W = 32;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [PC_W-1:0]     in_pc;
  logic [INSTR_W-1:0]  in_instr;
  logic                out_valid;
  logic                out_ready;
  logic [PC_W-1:0]     out_pc;
  logic [OPCODE_W-1:0] out_opcode;
  logic [REG_W-1:0]    out_rs, out_rt, out_rd;
  logic [IMM_W-1:0]    out_imm;
  logic                out_insmsb;
  logic [SHAMT_W-1:0]  out_shamt;
`ifdef INSTR_DECODE_STATS_EN
  logic [STAT_W-1:0]   stat_decoded, stat_stall;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instr_decode_reg #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pc      (in_pc),
    .in_instr   (in_instr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_opcode (out_opcode),
    .out_rs     (out_rs),
    .out_rt     (out_rt),
    .out_rd     (out_rd),
    .out_imm    (out_imm),
    .out_insmsb (out_insmsb),
`ifdef INSTR_DECODE_STATS_EN
    .stat_decoded (stat_decoded),
    .stat_stall   (stat_stall),
`endif
    .out_shamt  (out_shamt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] out_word();
    return {out_opcode, out_rs, out_imm};
  endfunction

  task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] pc);
    in_valid = v;
    in_instr = w;
    in_pc    = pc;
  endtask

  logic seen_full;
  int   emitted;

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instr = '0;
    #12;
    chk("rst_in_ready",  64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_fields",    64'({out_word(), out_rd, out_shamt, out_insmsb}), 64'd0);
    chk("rst_pc",        64'(out_pc), 64'd0);

    // Single accept, latency one cycle
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 32'h8C22_0004, 32'h100);
    step();
    drive(1'b0, 32'h0, 32'h0);
    chk("lw_valid",  64'(out_valid), 64'd1);
    chk("lw_opcode", 64'(out_opcode), 64'h23);
    chk("lw_rs",     64'(out_rs), 64'd1);
    chk("lw_rt",     64'(out_rt), 64'd2);
    chk("lw_imm",    64'(out_imm), 64'h020004);
    chk("lw_insmsb", 64'(out_insmsb), 64'd1);
    chk("lw_pc",     64'(out_pc), 64'h100);
    step();
    chk("lw_drain_valid", 64'(out_valid), 64'd0);
    chk("lw_hold_opcode", 64'(out_opcode), 64'h23);

    // Backpressure: A, B buffered, C held off, then drained in order
    out_ready = 1'b0;
    drive(1'b1, 32'hA000_000A, 32'h200);
    step();
    chk("bp_a_valid", 64'(out_valid), 64'd1);
    chk("bp_a_ready", 64'(in_ready), 64'd1);
    drive(1'b1, 32'hB000_000B, 32'h204);
    step();
    chk("bp_full_ready", 64'(in_ready), 64'd0);
    chk("bp_head_a", 64'(out_word()), 64'hA000_000A);
    drive(1'b1, 32'hC000_000C, 32'h208);
    step();
    chk("bp_hold_ready", 64'(in_ready), 64'd0);
    chk("bp_stable_a", 64'(out_word()), 64'hA000_000A);
    chk("bp_stable_pc", 64'(out_pc), 64'h200);
    out_ready = 1'b1;
    step();
    chk("bp_out_b", 64'(out_word()), 64'hB000_000B);
    chk("bp_b_ready", 64'(in_ready), 64'd1);
    step();
    drive(1'b0, 32'h0, 32'h0);
    chk("bp_out_c", 64'(out_word()), 64'hC000_000C);
    chk("bp_out_c_pc", 64'(out_pc), 64'h208);
    step();
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Streaming at one word per cycle
    seen_full = 1'b0;
    emitted = 0;
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 32'h1000_0000 + 32'(i), 32'(i) * 32'd4);
      step();
      if (!in_ready) seen_full = 1'b1;
      if (out_valid) emitted++;
      chk("stream_word", 64'(out_word()), 64'(32'h1000_0000 + 32'(i)));
    end
    drive(1'b0, 32'h0, 32'h0);
    step();
    chk("stream_count", 64'(emitted), 64'd100);
    chk("stream_never_full", 64'(seen_full), 64'd0);
    chk("stream_last_pc", 64'(out_pc), 64'd396);
    chk("stream_drained", 64'(out_valid), 64'd0);

    // Flush from FULL beats a simultaneous accept and consume
    out_ready = 1'b0;
    drive(1'b1, 32'h2000_0001, 32'h300);
    step();
    drive(1'b1, 32'h2000_0002, 32'h304);
    step();
    chk("fl_full", 64'(in_ready), 64'd0);
    flush = 1'b1; out_ready = 1'b1;
    drive(1'b1, 32'h2000_0003, 32'h308);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_ready", 64'(in_ready), 64'd1);
    chk("fl_hold_word", 64'(out_word()), 64'h2000_0001);
    step();
    chk("fl_no_accept", 64'(out_valid), 64'd0);

    // Asynchronous reset while FULL
    out_ready = 1'b0;
    drive(1'b1, 32'h3000_0001, 32'h400);
    step();
    drive(1'b1, 32'h3000_0002, 32'h404);
    step();
    chk("ar_full", 64'(in_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(out_valid), 64'd0);
    chk("ar_ready", 64'(in_ready), 64'd1);
    chk("ar_fields", 64'({out_word(), out_rd, out_shamt, out_insmsb}), 64'd0);
    chk("ar_pc", 64'(out_pc), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_07C0, 32'h500);
    step();
    drive(1'b0, 32'h0, 32'h0);
    chk("ar_first_valid", 64'(out_valid), 64'd1);
    chk("ar_shamt", 64'(out_shamt), 64'h1F);
    chk("ar_insmsb", 64'(out_insmsb), 64'd0);
    chk("ar_rd", 64'(out_rd), 64'd0);
    chk("ar_pc_after", 64'(out_pc), 64'h500);
    step();
    chk("ar_no_dup", 64'(out_valid), 64'd0);

`ifdef INSTR_DECODE_STATS_EN
    chk("st_cleared_after_rst", 64'(stat_stall), 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      drive(1'b1, 32'(i), 32'(i));
      step();
    end
    drive(1'b0, 32'h0, 32'h0);
    step();
    chk("st_decoded_sat", 64'(stat_decoded), 64'hFFFF);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("st_flush_clear", 64'(stat_decoded), 64'd0);
    out_ready = 1'b0;
    drive(1'b1, 32'h4000_0000, 32'h600);
    step();
    drive(1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) step();
    chk("st_stall", 64'(stat_stall), 64'd5);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_decode_reg.md
INSTR_DECODE_REG -- requirements
Module: instr_decode_reg

Interface
REQ-001 Parameter PC_W, default 32, width of the program-counter field carried with each instruction.
REQ-002 Parameter INSTR_W, default 32, instruction width; only 32 is supported.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 flush  in  1  discard all held instructions (branch/jump redirect).
REQ-006 in_valid  in  1  fetch presents an instruction.
REQ-007 in_ready  out  1  block can accept this cycle.
REQ-008 in_pc  in  PC_W  PC of the presented instruction.
REQ-009 in_instr  in  INSTR_W  raw instruction word.
REQ-010 out_valid  out  1  decoded fields valid.
REQ-011 out_ready  in  1  downstream (immediate extender / ALU operand stage) consumes.
REQ-012 out_pc  out  PC_W  PC of the head instruction.
REQ-013 out_opcode  out  6  instr[31:26].
REQ-014 out_rs, out_rt, out_rd  out  5 each  instr[25:21], instr[20:16], instr[15:11].
REQ-015 out_imm  out  21  instr[20:0], feeds the immediate extender imm input unchanged.
REQ-016 out_insmsb  out  1  instr[31], feeds the immediate extender select input.
REQ-017 out_shamt  out  5  instr[10:6].

Function
REQ-018 The block SHALL be a 2-entry skid buffer with states EMPTY, ONE, FULL, encoded in a registered state variable.
REQ-019 Accept = in_valid & in_ready; consume = out_valid & out_ready.
REQ-020 in_ready SHALL be a registered output, 1 in EMPTY and ONE, 0 in FULL.
REQ-021 out_valid SHALL be 1 exactly in ONE and FULL; all out_* fields are decoded from the head entry and registered.
REQ-022 Transitions: EMPTY+accept->ONE; ONE+accept-only->FULL; ONE+consume-only->EMPTY; ONE+accept+consume->ONE (new word becomes head next cycle); FULL+consume->ONE (second entry becomes head); otherwise hold.
REQ-023 Latency: instruction accepted in cycle N SHALL appear on out_* with out_valid=1 in cycle N+1 when the buffer was EMPTY or held only a consumed head.
REQ-024 Ordering SHALL be strict FIFO; no instruction duplicated or dropped except by flush.
REQ-025 Field outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 flush SHALL force EMPTY on the next edge, override any simultaneous accept or consume, and leave in_ready=1, out_valid=0 next cycle.
REQ-027 In EMPTY, out_* fields SHALL hold their last values (not cleared); consumers qualify with out_valid.

Reset
REQ-028 On rst_n=0, asynchronously: state=EMPTY, in_ready=1, out_valid=0, all out_* fields and both entries=0.
REQ-029 Reset mid-operation SHALL discard all held instructions; the first accept after release behaves as from EMPTY.

Configuration
REQ-030 Macro INSTR_DECODE_STATS_EN, when defined, SHALL add outputs stat_decoded[15:0] (increments per consume) and stat_stall[15:0] (increments per cycle with out_valid=1, out_ready=0), both saturating at 16'hFFFF, cleared by reset and flush.
REQ-031 Without INSTR_DECODE_STATS_EN the ports and counters SHALL be absent; all other behaviour is identical.

Structure
REQ-032 Field bit positions (opcode, rs, rt, rd, shamt, imm LSB/MSB, insmsb) and state encoding SHALL live in shared package cpu_pkg, used also by the extender and control decoder.
REQ-033 One sub-module, instr_fields, SHALL perform purely combinational field slicing; the parent holds storage and handshake.

Verification
REQ-034 Reset then single accept of in_instr=32'h8C22_0004, in_pc=0x100, out_ready=1 -> next cycle out_valid=1, opcode=6'h23, rs=1, rt=2, out_imm=21'h020004, out_insmsb=1.
REQ-035 out_ready=0, three back-to-back valid words A,B,C -> A,B accepted, in_ready=0 from cycle 2, C held; release out_ready -> A,B,C emitted in order, one per cycle.
REQ-036 Continuous in_valid=1, out_ready=1 with 100 incrementing words -> throughput 1/cycle, state never FULL, output sequence matches input.
REQ-037 FULL buffer, flush=1 with simultaneous in_valid=1, out_ready=1 -> next cycle out_valid=0, in_ready=1, no word emitted or accepted.
REQ-038 rst_n pulled low mid-stream in FULL -> outputs zero immediately (asynchronously); after release, first word 0x0000_07C0 yields out_shamt=5'h1F, out_insmsb=0.
REQ-039 With INSTR_DECODE_STATS_EN: 70000 consumes -> stat_decoded=16'hFFFF; 5 stalled cycles -> stat_stall=5.
